axis_sink_controller: RTL and testbench

//  Testbench-side sink controller for one AXI-stream output of the compressor under test.

---
 rtl/axis_sink_controller_pkg.sv | 24 ++
 rtl/axis_sink_controller_if.sv | 11 +
 rtl/axis_sink_controller_ready_pattern_gen.sv | 53 +++++
 rtl/axis_sink_controller.sv | 138 +++++++++++++
 tb/tb_axis_sink_controller.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sink_controller_pkg.sv
// Shared types and helpers for the AXI-stream sink controller.
package axis_sink_controller_pkg;

   typedef enum logic [1:0] {
      ALWAYS   = 2'd0,
      PERIODIC = 2'd1,
      RANDOM   = 2'd2
   } sink_mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } sink_state_t;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
   localparam logic [15:0] LFSR16_POLY = 16'hB400;

   function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
      lfsr16_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/axis_sink_controller_if.sv
// Monitored AXI-stream link: producer drives valid/data, the sink drives ready.
interface axis_sink_controller_if #(
   parameter int DATA_WIDTH = 10
);
   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_sink_controller_ready_pattern_gen.sv
// Back-pressure pattern source: phase counter, LFSR and mode select producing the next ready value.
module ready_pattern_gen
   import axis_sink_controller_pkg::*;
#(
   parameter int          MODE            = 0,
   parameter int          READY_PERIOD    = 4,
   parameter int          READY_HIGH      = 2,
   parameter int          READY_THRESHOLD = 128,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   input  logic i_restart,
   output logic o_ready_next
);

   localparam int                 PHASE_W    = $clog2(READY_PERIOD + 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(READY_PERIOD - 1);
   localparam logic [PHASE_W-1:0] HIGH_CMP   = PHASE_W'(READY_HIGH);
   localparam logic [8:0]         THR_CMP    = 9'(READY_THRESHOLD);
   localparam sink_mode_t         MODE_E     = sink_mode_t'(MODE[1:0]);

   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] w_phase_eff;
   logic [PHASE_W-1:0] w_phase_nxt;
   logic [15:0]        r_lfsr;
   logic [15:0]        w_lfsr_eff;

   // A restart evaluates the pattern from its initial point in the same cycle it is loaded
   always_comb begin
      w_phase_eff = i_restart ? '0 : r_phase;
      w_lfsr_eff  = i_restart ? LFSR_SEED : r_lfsr;
      w_phase_nxt = (w_phase_eff == PHASE_LAST) ? '0 : w_phase_eff + PHASE_W'(1);
      case (MODE_E)
         ALWAYS:   o_ready_next = 1'b1;
         PERIODIC: o_ready_next = (w_phase_eff < HIGH_CMP);
         RANDOM:   o_ready_next = ({1'b0, w_lfsr_eff[7:0]} < THR_CMP);
         default:  o_ready_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase <= '0;
         r_lfsr  <= LFSR_SEED;
      end else if (i_enable || i_restart) begin
         r_phase <= w_phase_nxt;
         r_lfsr  <= lfsr16_step(w_lfsr_eff);
      end
   end

endmodule

// File: rtl/axis_sink_controller.sv
// AXI-stream sink controller: programmable back-pressure, beat counting, completion,
// stall watchdog and producer-side handshake checking.
module axis_sink_controller
   import axis_sink_controller_pkg::*;
#(
   parameter int          DATA_WIDTH      = 10,
   parameter int          EXPECTED_COUNT  = 1024,
   parameter int          MODE            = 0,
   parameter int          READY_PERIOD    = 4,
   parameter int          READY_HIGH      = 2,
   parameter int          READY_THRESHOLD = 128,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          TIMEOUT_CYCLES  = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   axis_sink_controller_if.slave s_axis,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout,
   output logic                  o_protocol_error,
   output logic [31:0]           o_beat_count
);

   localparam logic [31:0] EXP_CNT     = 32'(EXPECTED_COUNT);
   localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT_CYCLES);

   sink_state_t           r_state;
   sink_state_t           w_state_nxt;
   logic                  r_ready;
   logic                  r_done;
   logic                  r_timeout;
   logic                  r_protocol_error;
   logic [31:0]           r_beat_count;
   logic [31:0]           r_watchdog;
   logic                  r_stall;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_in_run;
   logic                  w_transfer;
   logic                  w_last;
   logic                  w_expire;
   logic [31:0]           w_wd_inc;
   logic                  w_start_run;
   logic                  w_gen_enable;
   logic                  w_ready_next;
   logic                  w_violation;

   assign w_in_run    = (r_state == RUN);
   assign w_transfer  = s_axis.valid & r_ready;
   assign w_last      = w_transfer && ((r_beat_count + 32'd1) == EXP_CNT);
   assign w_wd_inc    = r_watchdog + 32'd1;
   // A transfer in the expiry cycle wins over the watchdog
   assign w_expire    = !w_transfer && (w_wd_inc >= TIMEOUT_CNT);
   assign w_violation = r_stall && (!s_axis.valid || (s_axis.data != r_data));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start_run  = 1'b0;
      w_gen_enable = 1'b0;
      case (r_state)
         IDLE, DONE, TIMEOUT: begin
            if (i_start) begin
               w_state_nxt = RUN;
               w_start_run = 1'b1;
            end
         end
         RUN: begin
            if (w_last)        w_state_nxt = DONE;
            else if (w_expire) w_state_nxt = TIMEOUT;
            else               w_gen_enable = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   ready_pattern_gen #(
      .MODE            (MODE),
      .READY_PERIOD    (READY_PERIOD),
      .READY_HIGH      (READY_HIGH),
      .READY_THRESHOLD (READY_THRESHOLD),
      .LFSR_SEED       (LFSR_SEED)
   ) u_ready_gen (
      .clk          (clk),
      .rst          (rst),
      .i_enable     (w_gen_enable),
      .i_restart    (w_start_run),
      .o_ready_next (w_ready_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready          <= 1'b0;
         r_done           <= 1'b0;
         r_timeout        <= 1'b0;
         r_protocol_error <= 1'b0;
         r_beat_count     <= 32'd0;
         r_watchdog       <= 32'd0;
         r_stall          <= 1'b0;
         r_data           <= '0;
      end else begin
         r_ready <= (w_state_nxt == RUN) ? w_ready_next : 1'b0;
         r_stall <= w_in_run & s_axis.valid & ~r_ready;
         r_data  <= s_axis.data;
         if (w_start_run) begin
            r_done           <= 1'b0;
            r_timeout        <= 1'b0;
            r_protocol_error <= 1'b0;
            r_beat_count     <= 32'd0;
            r_watchdog       <= 32'd0;
         end else if (w_in_run) begin
            if (w_transfer) begin
               r_beat_count <= r_beat_count + 32'd1;
               r_watchdog   <= 32'd0;
            end else begin
               r_watchdog   <= w_wd_inc;
            end
            if (w_last)      r_done           <= 1'b1;
            if (w_expire)    r_timeout        <= 1'b1;
            if (w_violation) r_protocol_error <= 1'b1;
         end
      end
   end

   assign s_axis.ready     = r_ready;
   assign o_busy           = w_in_run;
   assign o_done           = r_done;
   assign o_timeout        = r_timeout;
   assign o_protocol_error = r_protocol_error;
   assign o_beat_count     = r_beat_count;

endmodule

// File: tb/tb_axis_sink_controller.sv
// Bench for axis_sink_controller: three configurations (always, periodic, random-never-ready).
module tb_axis_sink_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;
   logic busy0, done0, to0, pe0;
   logic busy1, done1, to1, pe1;
   logic busy2, done2, to2, pe2;
   logic [31:0] bc0, bc1, bc2;

   axis_sink_controller_if #(.DATA_WIDTH(10)) if0 ();
   axis_sink_controller_if #(.DATA_WIDTH(10)) if1 ();
   axis_sink_controller_if #(.DATA_WIDTH(10)) if2 ();

   int          errors = 0;
   int          checks = 0;
   int          sb_q[$];
   logic [31:0] prev_bc;

   axis_sink_controller #(
      .DATA_WIDTH(10), .EXPECTED_COUNT(8), .MODE(0), .READY_PERIOD(4), .READY_HIGH(2),
      .READY_THRESHOLD(128), .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(16)
   ) u_dut0 (
      .clk(clk), .rst(rst), .i_start(start0), .s_axis(if0), .o_busy(busy0), .o_done(done0),
      .o_timeout(to0), .o_protocol_error(pe0), .o_beat_count(bc0)
   );

   axis_sink_controller #(
      .DATA_WIDTH(10), .EXPECTED_COUNT(8), .MODE(1), .READY_PERIOD(4), .READY_HIGH(1),
      .READY_THRESHOLD(128), .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(64)
   ) u_dut1 (
      .clk(clk), .rst(rst), .i_start(start1), .s_axis(if1), .o_busy(busy1), .o_done(done1),
      .o_timeout(to1), .o_protocol_error(pe1), .o_beat_count(bc1)
   );

   axis_sink_controller #(
      .DATA_WIDTH(10), .EXPECTED_COUNT(8), .MODE(2), .READY_PERIOD(4), .READY_HIGH(2),
      .READY_THRESHOLD(0), .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(20)
   ) u_dut2 (
      .clk(clk), .rst(rst), .i_start(start2), .s_axis(if2), .o_busy(busy2), .o_done(done2),
      .o_timeout(to2), .o_protocol_error(pe2), .o_beat_count(bc2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      if0.valid = 1'b0; if0.data = '0;
      if1.valid = 1'b0; if1.data = '0;
      if2.valid = 1'b0; if2.data = '0;
      #2;
      checks++; if (if0.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", if0.ready); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done0); end
      checks++; if (to0 !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", to0); end
      checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", pe0); end
      checks++; if (bc0 !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bc0); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      checks++; if (busy0 !== 1'b0 || if0.ready !== 1'b0) begin
         errors++; $display("FAIL idle_no_start: got busy=%0b ready=%0b expected 0 0", busy0, if0.ready);
      end
   endtask

   // MODE0: ready every cycle, done on beat 8, ready drops the next cycle
   task automatic test_always_ready();
      int model;
      int exp;
      model = 0;
      sb_q.delete();
      if0.valid = 1'b1; if0.data = 10'd0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      prev_bc = 32'd0;
      checks++; if (busy0 !== 1'b1 || bc0 !== 32'd0) begin
         errors++; $display("FAIL t1_start: got busy=%0b count=%0d expected 1 0", busy0, bc0);
      end
      for (int c = 0; c < 8; c++) begin
         checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL t1_ready c=%0d: got %0b expected 1", c, if0.ready); end
         checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL t1_done_early c=%0d: got %0b expected 0", c, done0); end
         model++; sb_q.push_back(model);
         tick();
         if0.data = 10'(c + 1);
         if (bc0 !== prev_bc) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL t1_extra_beat: got count %0d expected no beat", bc0); end
            else begin
               exp = sb_q.pop_front();
               if (bc0 !== 32'(exp)) begin errors++; $display("FAIL t1_count: got %0d expected %0d", bc0, exp); end
            end
            prev_bc = bc0;
         end
      end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t1_missing_beats: got %0d pending expected 0", sb_q.size()); end
      checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL t1_done: got %0b expected 1", done0); end
      checks++; if (if0.ready !== 1'b0) begin errors++; $display("FAIL t1_ready_after_done: got %0b expected 0", if0.ready); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL t1_busy_after_done: got %0b expected 0", busy0); end
      tick();
      checks++; if (bc0 !== 32'd8 || if0.ready !== 1'b0) begin
         errors++; $display("FAIL t1_hold: got count=%0d ready=%0b expected 8 0", bc0, if0.ready);
      end
   endtask

   // MODE1 period 4 high 1: ready pattern 1000, eighth beat at cycle 28
   task automatic test_periodic();
      int   model;
      int   exp;
      logic exp_rdy;
      model = 0;
      sb_q.delete();
      if1.valid = 1'b1; if1.data = 10'h2A5;
      start1 = 1'b1; tick(); start1 = 1'b0;
      prev_bc = 32'd0;
      for (int c = 0; c < 29; c++) begin
         exp_rdy = ((c % 4) == 0);
         checks++; if (if1.ready !== exp_rdy) begin errors++; $display("FAIL t2_ready c=%0d: got %0b expected %0b", c, if1.ready, exp_rdy); end
         checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL t2_done_early c=%0d: got %0b expected 0", c, done1); end
         if (exp_rdy) begin model++; sb_q.push_back(model); end
         tick();
         if (bc1 !== prev_bc) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL t2_extra_beat: got count %0d expected no beat", bc1); end
            else begin
               exp = sb_q.pop_front();
               if (bc1 !== 32'(exp)) begin errors++; $display("FAIL t2_count: got %0d expected %0d", bc1, exp); end
            end
            prev_bc = bc1;
         end
      end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t2_missing_beats: got %0d pending expected 0", sb_q.size()); end
      checks++; if (done1 !== 1'b1 || bc1 !== 32'd8) begin
         errors++; $display("FAIL t2_done: got done=%0b count=%0d expected 1 8", done1, bc1);
      end
      checks++; if (if1.ready !== 1'b0 || pe1 !== 1'b0) begin
         errors++; $display("FAIL t2_end: got ready=%0b perr=%0b expected 0 0", if1.ready, pe1);
      end
   endtask

   // MODE2 threshold 0: never ready, timeout exactly 20 cycles after start
   task automatic test_random_timeout();
      if2.valid = 1'b1; if2.data = 10'h133;
      start2 = 1'b1; tick(); start2 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         checks++; if (if2.ready !== 1'b0) begin errors++; $display("FAIL t3_ready c=%0d: got %0b expected 0", c, if2.ready); end
         checks++; if (to2 !== 1'b0) begin errors++; $display("FAIL t3_timeout_early c=%0d: got %0b expected 0", c, to2); end
         tick();
      end
      checks++; if (to2 !== 1'b1) begin errors++; $display("FAIL t3_timeout: got %0b expected 1", to2); end
      checks++; if (busy2 !== 1'b0 || bc2 !== 32'd0 || done2 !== 1'b0) begin
         errors++; $display("FAIL t3_state: got busy=%0b count=%0d done=%0b expected 0 0 0", busy2, bc2, done2);
      end
      checks++; if (pe2 !== 1'b0) begin errors++; $display("FAIL t3_perr: got %0b expected 0", pe2); end
   endtask

   // Protocol violations on the periodic instance (ready low in cycles 1..3 of each period)
   task automatic test_protocol();
      if1.valid = 1'b0; if1.data = 10'h011;
      start1 = 1'b1; tick(); start1 = 1'b0;
      checks++; if (pe1 !== 1'b0 || done1 !== 1'b0) begin
         errors++; $display("FAIL t4_restart_clear: got perr=%0b done=%0b expected 0 0", pe1, done1);
      end
      tick();
      if1.valid = 1'b1; if1.data = 10'h155;
      tick();
      checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL t4_stall_ok: got %0b expected 0", pe1); end
      if1.valid = 1'b0;
      tick();
      checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL t4_valid_drop: got %0b expected 1", pe1); end
      if1.valid = 1'b1;
      repeat (3) tick();
      checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL t4_sticky: got %0b expected 1", pe1); end
      for (int k = 0; k < 64 && done1 !== 1'b1; k++) tick();
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL t4_done_bound: got %0b expected 1", done1); end
      checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL t4_sticky_done: got %0b expected 1", pe1); end
      if1.valid = 1'b0;
      start1 = 1'b1; tick(); start1 = 1'b0;
      checks++; if (pe1 !== 1'b0 || bc1 !== 32'd0) begin
         errors++; $display("FAIL t4_start_clears: got perr=%0b count=%0d expected 0 0", pe1, bc1);
      end
      tick();
      if1.valid = 1'b1; if1.data = 10'h0F0;
      tick();
      if1.data = 10'h0F1;
      tick();
      checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL t4_data_change: got %0b expected 1", pe1); end
   endtask

   // Transfer in the expiry cycle suppresses the timeout and clears the watchdog
   task automatic test_watchdog_transfer();
      int exp;
      sb_q.delete();
      if0.valid = 1'b0; if0.data = 10'h00F;
      start0 = 1'b1; tick(); start0 = 1'b0;
      prev_bc = 32'd0;
      repeat (15) tick();
      checks++; if (to0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++; $display("FAIL t6_pre: got timeout=%0b busy=%0b expected 0 1", to0, busy0);
      end
      if0.valid = 1'b1; sb_q.push_back(1);
      tick();
      if0.valid = 1'b0;
      checks++; if (to0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++; $display("FAIL t6_priority: got timeout=%0b busy=%0b expected 0 1", to0, busy0);
      end
      if (bc0 !== prev_bc) begin
         checks++;
         exp = sb_q.pop_front();
         if (bc0 !== 32'(exp)) begin errors++; $display("FAIL t6_count: got %0d expected %0d", bc0, exp); end
         prev_bc = bc0;
      end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t6_missing_beat: got %0d pending expected 0", sb_q.size()); end
      repeat (15) tick();
      checks++; if (to0 !== 1'b0) begin errors++; $display("FAIL t6_wd_cleared: got %0b expected 0", to0); end
      tick();
      checks++; if (to0 !== 1'b1 || busy0 !== 1'b0 || bc0 !== 32'd1) begin
         errors++; $display("FAIL t6_expire: got timeout=%0b busy=%0b count=%0d expected 1 0 1", to0, busy0, bc0);
      end
   endtask

   // Asynchronous reset at beat 5, then a clean run
   task automatic test_reset_midrun();
      if0.valid = 1'b1; if0.data = 10'h3C3;
      start0 = 1'b1; tick(); start0 = 1'b0;
      repeat (5) tick();
      checks++; if (bc0 !== 32'd5) begin errors++; $display("FAIL t5_beat5: got %0d expected 5", bc0); end
      #2 rst = 1'b0;
      #1;
      checks++; if (if0.ready !== 1'b0 || busy0 !== 1'b0) begin
         errors++; $display("FAIL t5_async_ctl: got ready=%0b busy=%0b expected 0 0", if0.ready, busy0);
      end
      checks++; if (done0 !== 1'b0 || to0 !== 1'b0 || pe0 !== 1'b0 || bc0 !== 32'd0) begin
         errors++; $display("FAIL t5_async_sts: got done=%0b timeout=%0b perr=%0b count=%0d expected 0 0 0 0", done0, to0, pe0, bc0);
      end
      #2 rst = 1'b1;
      tick();
      checks++; if (busy0 !== 1'b0 || bc0 !== 32'd0) begin
         errors++; $display("FAIL t5_idle: got busy=%0b count=%0d expected 0 0", busy0, bc0);
      end
      start0 = 1'b1; tick(); start0 = 1'b0;
      for (int k = 0; k < 20 && done0 !== 1'b1; k++) tick();
      checks++; if (done0 !== 1'b1 || bc0 !== 32'd8 || to0 !== 1'b0) begin
         errors++; $display("FAIL t5_clean_run: got done=%0b count=%0d timeout=%0b expected 1 8 0", done0, bc0, to0);
      end
   endtask

   initial begin
      test_reset();
      test_always_ready();
      test_periodic();
      test_random_timeout();
      test_protocol();
      test_watchdog_transfer();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got no finish expected finish before 100000");
      $fatal(1, "bench time limit expired");
   end

endmodule
